change_dispenser: RTL and testbench
===================================

# change_dispenser

Downstream consumer of the vending controller's change-return pulses. It accepts the one-cycle `DROP50`/`DROP100`/`DROP500`/`DROP1000` strobes, which can arrive back-to-back on consecutive clocks, and buffers them in a small FIFO. Each queued coin is then ejected by driving one hopper motor at a time, confirmed by the hopper's coin-out sensor. The block detects hopper jams by timeout, holds the failed coin until service clears the jam, and keeps a running total of value paid out.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries (power of two, at least 2).
- `TIMEOUT`, default 255: maximum DRIVE cycles without `HOP_SENSE` before a jam is declared.
- `GAP_CYCLES`, default 4: motor-off cycles between consecutive coins.

Ports:
- `CLK`  in  1  System clock. One clock domain; all logic on the rising edge.
- `RST_N`  in  1  Reset, asynchronous and active-low.
- `DROP50`, `DROP100`, `DROP500`, `DROP1000`  in  1 each  One-cycle dispense requests from the controller.
- `HOP_SENSE`  in  1  One-cycle coin-ejected pulse from the hopper. Already synchronous to `CLK`.
- `CLR_JAM`  in  1  One-cycle service pulse. Retries the jammed coin and clears the sticky flags.
- `MOTOR`  out  4  One-hot, registered hopper drive. Bit 0 = 50, bit 1 = 100, bit 2 = 500, bit 3 = 1000.
- `BUSY`  out  1  High when the FIFO is non-empty or the FSM is not in IDLE.
- `FULL`  out  1  FIFO holds `DEPTH` entries.
- `JAM`  out  1  FSM is in JAM.
- `JAM_CODE`  out  2  Denomination code of the jammed coin. Valid while `JAM`=1.
- `OVF`  out  1  Sticky: a request was lost because the FIFO was full.
- `MULTI`  out  1  Sticky: more than one `DROP*` was asserted in the same cycle.
- `PAID`  out  16  Value dispensed, in units of 50. Saturating.

## Operation
- Denomination codes: 0 = 50, 1 = 100, 2 = 500, 3 = 1000. Value weights are 1, 2, 10, 20.
- Enqueue:
  - Any `DROP*` high pushes one code at the clock edge.
  - If several `DROP*` are high in the same cycle, only the highest denomination is pushed and `MULTI` is set.
  - A push when `FULL`=1 and no pop in the same cycle is discarded and sets `OVF`.
  - A push and a pop in the same cycle are both honoured, including when full; the count is unchanged.
- FSM states: IDLE, DRIVE, GAP, JAM.
  - IDLE: when the FIFO is non-empty, pop the head, latch it into `cur`, clear the timeout counter, go to DRIVE.
  - DRIVE: `MOTOR[cur]`=1; the timeout counter increments each cycle.
    - `HOP_SENSE`=1 → add weight(`cur`) to `PAID` (saturating at 0xFFFF), go to GAP.
    - Otherwise, counter reaching `TIMEOUT` → go to JAM.
    - If `HOP_SENSE` arrives in the same cycle the timeout is reached, `HOP_SENSE` wins.
  - GAP: `MOTOR`=0 for `GAP_CYCLES` cycles, then go to IDLE.
  - JAM: `MOTOR`=0, `JAM`=1, `JAM_CODE`=`cur`; the FIFO keeps accepting requests.
    - `CLR_JAM` → clear the counter, clear `OVF` and `MULTI`, return to DRIVE with the same `cur`.
- `HOP_SENSE` outside DRIVE is ignored and `PAID` is unchanged.
- `CLR_JAM` outside JAM clears `OVF` and `MULTI` only.
- Reset: at `RST_N`=0, immediately and without waiting for a clock edge, force the following to their reset values, and hold them until reset is released:
  - FIFO empty; state IDLE.
  - `MOTOR`=0, `BUSY`=0, `FULL`=0, `JAM`=0, `JAM_CODE`=0, `OVF`=0, `MULTI`=0, `PAID`=0.
  - If reset hits mid-DRIVE, the motor stops at once and the coin in flight is discarded, not paid.

## Timing
- A `DROP*` sampled at edge t is in the FIFO after edge t.
- IDLE pops at edge t+1; `MOTOR` is high from edge t+2, so request-to-motor latency is 2 cycles.
- `MOTOR` falls at the edge that samples `HOP_SENSE`; `PAID` updates at the same edge.
- Coin-to-coin spacing is (DRIVE cycles) + `GAP_CYCLES` + 1 cycle in IDLE.
- Jam: with no sense, `JAM` asserts `TIMEOUT`+1 cycles after `MOTOR` rises.
- After `CLR_JAM` at edge t, `MOTOR` is high again from edge t+1.
- The controller's four back-to-back RET drops (RET0/RET1b/RET2b/RET3b, spacing ≥1 cycle) must never overflow at `DEPTH`=8.
- `FULL` and `BUSY` are derived from registered state; no combinational path from `DROP*` to any output.

## Test plan
- Single coin: `DROP500` pulse, `HOP_SENSE` 5 cycles after `MOTOR` rises → `MOTOR`=4'b0100 from cycle 2, `PAID`=10, `BUSY` low after GAP + 1 cycle.
- Burst: `DROP1000`, `DROP100`, `DROP100`, `DROP50` on consecutive cycles, sense after 3 cycles each → motors fire in order 1000, 100, 100, 50; `PAID`=25; `OVF`=0.
- Jam: `DROP100`, no sense → `JAM`=1 and `JAM_CODE`=1 after 256 motor cycles; `CLR_JAM` then sense → `PAID`=2, `JAM`=0.
- Overflow/multi: hold `HOP_SENSE` low, push 10 single drops → `FULL`=1, `OVF`=1. Assert `DROP50`+`DROP1000` together → code 3 queued (not lost, once space exists), `MULTI`=1.
- Sense/timeout tie: `HOP_SENSE` in the exact cycle the counter hits `TIMEOUT` → GAP, not JAM; `PAID` increments.
- Reset mid-DRIVE: assert `RST_N`=0 while `MOTOR`≠0 → `MOTOR`=0 before the next clock edge, all outputs at reset values, queued coins gone.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin hopper sequencer: queues change-return strobes and ejects them one
// coin at a time with sensor confirmation, jam timeout and a paid total.
module change_dispenser #(
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DROP50,
    input  logic        DROP100,
    input  logic        DROP500,
    input  logic        DROP1000,
    input  logic        HOP_SENSE,
    input  logic        CLR_JAM,
    output logic [3:0]  MOTOR,
    output logic        BUSY,
    output logic        FULL,
    output logic        JAM,
    output logic [1:0]  JAM_CODE,
    output logic        OVF,
    output logic        MULTI,
    output logic [15:0] PAID
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP,
        S_JAM
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic [1:0]      cur_q, cur_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [3:0]      motor_q, motor_d;
    logic [15:0]     paid_q, paid_d;
    logic            ovf_q, ovf_d;
    logic            multi_q, multi_d;

    logic [3:0]      drops;
    logic [1:0]      push_code;
    logic            push_req, push_ok, pop, full;
    logic [16:0]     sum;

    function automatic logic [4:0] weight(input logic [1:0] c);
        case (c)
            2'd0:    weight = 5'd1;
            2'd1:    weight = 5'd2;
            2'd2:    weight = 5'd10;
            default: weight = 5'd20;
        endcase
    endfunction

    assign drops    = {DROP1000, DROP500, DROP100, DROP50};
    assign push_req = |drops;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        push_code = 2'd0;
        if (DROP1000)     push_code = 2'd3;
        else if (DROP500) push_code = 2'd2;
        else if (DROP100) push_code = 2'd1;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        paid_d  = paid_q;
        pop     = 1'b0;
        sum     = {1'b0, paid_q} + {12'd0, weight(cur_q)};
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cur_d   = mem_q[rptr_q];
                    tcnt_d  = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Only motor-on cycles count toward the jam timeout.
                if (motor_q != 4'd0) tcnt_d = tcnt_q + 1'b1;
                if (HOP_SENSE) begin
                    paid_d  = sum[16] ? 16'hFFFF : sum[15:0];
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    state_d = S_JAM;
                end
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else gcnt_d = gcnt_q + 1'b1;
            end
            S_JAM: begin
                if (CLR_JAM) begin
                    tcnt_d  = '0;
                    state_d = S_DRIVE;
                end
            end
        endcase
    end

    always_comb begin
        motor_d = 4'd0;
        if (state_q == S_DRIVE && state_d == S_DRIVE)
            motor_d = 4'b0001 << cur_q;
        ovf_d   = CLR_JAM ? 1'b0 : ovf_q;
        multi_d = CLR_JAM ? 1'b0 : multi_q;
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (!$onehot0(drops))         multi_d = 1'b1;
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wptr_q] <= push_code;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            cur_q   <= 2'd0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            motor_q <= 4'd0;
            paid_q  <= 16'd0;
            ovf_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            cur_q   <= cur_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            motor_q <= motor_d;
            paid_q  <= paid_d;
            ovf_q   <= ovf_d;
            multi_q <= multi_d;
        end
    end

    assign MOTOR    = motor_q;
    assign BUSY     = (count_q != '0) || (state_q != S_IDLE);
    assign FULL     = full;
    assign JAM      = (state_q == S_JAM);
    assign JAM_CODE = JAM ? cur_q : 2'd0;
    assign OVF      = ovf_q;
    assign MULTI    = multi_q;
    assign PAID     = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded bench for change_dispenser: model queue of expected coins,
// behavioural hopper, directed corner cases and randomized bursts.
module tb_change_dispenser;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int GAP     = 4;

    logic        CLK, RST_N;
    logic [3:0]  drop;
    logic        HOP_SENSE, CLR_JAM;
    logic [3:0]  MOTOR;
    logic        BUSY, FULL, JAM, OVF, MULTI;
    logic [1:0]  JAM_CODE;
    logic [15:0] PAID;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int cur_code  = 0;
    int exp_paid  = 0;
    int hop_delay = 3;
    bit stray     = 0;

    change_dispenser #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .DROP50(drop[0]), .DROP100(drop[1]),
        .DROP500(drop[2]), .DROP1000(drop[3]),
        .HOP_SENSE(HOP_SENSE), .CLR_JAM(CLR_JAM),
        .MOTOR(MOTOR), .BUSY(BUSY), .FULL(FULL), .JAM(JAM),
        .JAM_CODE(JAM_CODE), .OVF(OVF), .MULTI(MULTI), .PAID(PAID)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic int weight(input int c);
        case (c)
            0:       return 1;
            1:       return 2;
            2:       return 10;
            default: return 20;
        endcase
    endfunction

    function automatic int top_code(input logic [3:0] m);
        for (int i = 3; i >= 0; i--) if (m[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [3:0] m, input bit keep);
        drop = m;
        tick;
        drop = 4'd0;
        if (keep) exp_q.push_back(top_code(m));
    endtask

    task automatic pulse_clr;
        CLR_JAM = 1;
        tick;
        CLR_JAM = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (BUSY && n < budget) begin tick; n++; end
        chk({name, "_idle"}, BUSY, 0);
    endtask

    task automatic wait_motor(input string name);
        int n = 0;
        while (MOTOR == 0 && n < 20) begin tick; n++; end
        chk({name, "_motor_on"}, MOTOR != 0, 1);
    endtask

    task automatic wait_jam(input string name, output int n);
        n = 0;
        while (!JAM && n < 400) begin tick; n++; end
        chk({name, "_jam"}, JAM, 1);
    endtask

    // Monitor + hopper model: pops the scoreboard on each motor start and
    // answers with a sense pulse after hop_delay motor-on cycles.
    initial begin
        logic [3:0] mot_prev;
        int mcyc;
        bit fire;
        mot_prev = 0;
        mcyc = 0;
        HOP_SENSE = 0;
        forever begin
            @(negedge CLK);
            fire = 0;
            if (!RST_N) begin
                mcyc = 0;
            end else begin
                if (MOTOR != 0 && mot_prev == 0) begin
                    if (exp_q.size() == 0) begin
                        chk("motor_unexpected", MOTOR, 0);
                    end else begin
                        cur_code = exp_q.pop_front();
                        chk("motor_code", MOTOR, 32'd1 << cur_code);
                    end
                    mcyc = 0;
                end
                if (MOTOR != 0) begin
                    mcyc++;
                    if (mcyc == hop_delay) begin
                        fire = 1;
                        exp_paid = exp_paid + weight(cur_code);
                        if (exp_paid > 65535) exp_paid = 65535;
                    end
                end else begin
                    mcyc = 0;
                end
            end
            mot_prev = MOTOR;
            HOP_SENSE = fire | stray;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first;
        bit any_multi;
        logic [3:0] m;
        drop = 0;
        CLR_JAM = 0;
        RST_N = 1;
        #3 RST_N = 0;
        #20;
        chk("rst_motor", MOTOR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_full", FULL, 0);
        chk("rst_jam", JAM, 0);
        chk("rst_jamcode", JAM_CODE, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_multi", MULTI, 0);
        chk("rst_paid", PAID, 0);
        @(negedge CLK) RST_N = 1;
        tick;

        hop_delay = 5;
        send(4'b0100, 1);
        tick;
        chk("single_motor_t1", MOTOR, 0);
        tick;
        chk("single_motor_t2", MOTOR, 4'b0100);
        n = 0;
        while (MOTOR != 0 && n < 50) begin tick; n++; end
        chk("single_drive_cycles", n, 5);
        chk("single_paid", PAID, 10);
        repeat (GAP - 1) tick;
        chk("single_busy_gap", BUSY, 1);
        tick;
        tick;
        chk("single_busy_idle", BUSY, 0);

        stray = 1;
        tick;
        stray = 0;
        tick;
        chk("stray_sense_paid", PAID, exp_paid);

        hop_delay = 3;
        send(4'b1000, 1);
        send(4'b0010, 1);
        send(4'b0010, 1);
        send(4'b0001, 1);
        wait_idle("burst", 200);
        chk("burst_paid", PAID, exp_paid);
        chk("burst_paid_abs", PAID, 35);
        chk("burst_ovf", OVF, 0);
        chk("burst_q_empty", exp_q.size(), 0);

        hop_delay = -1;
        send(4'b0010, 1);
        wait_motor("jam");
        wait_jam("jam", n);
        chk("jam_latency", n, TIMEOUT + 1);
        chk("jam_code", JAM_CODE, 1);
        chk("jam_motor_off", MOTOR, 0);
        hop_delay = 3;
        exp_q.push_front(1);
        pulse_clr;
        chk("jam_cleared", JAM, 0);
        tick;
        chk("jam_retry_motor", MOTOR, 4'b0010);
        wait_idle("jam", 100);
        chk("jam_paid", PAID, exp_paid);

        hop_delay = TIMEOUT + 1;
        send(4'b0001, 1);
        wait_idle("tie", 600);
        chk("tie_no_jam", JAM, 0);
        chk("tie_paid", PAID, exp_paid);

        hop_delay = -1;
        first = 0;
        for (int i = 0; i < 10; i++) begin
            m = 4'd1 << $urandom_range(0, 3);
            if (i == 0) first = top_code(m);
            send(m, i < DEPTH + 1);
        end
        chk("ovf_full", FULL, 1);
        chk("ovf_flag", OVF, 1);
        wait_jam("ovf", n);
        chk("ovf_jam_code", JAM_CODE, first);
        hop_delay = 2;
        exp_q.push_front(first);
        pulse_clr;
        chk("ovf_cleared", OVF, 0);
        n = 0;
        while (FULL && n < 100) begin tick; n++; end
        chk("ovf_space", FULL, 0);
        send(4'b1001, 1);
        chk("multi_flag", MULTI, 1);
        wait_idle("ovf", 2000);
        chk("ovf_paid", PAID, exp_paid);
        chk("ovf_q_empty", exp_q.size(), 0);
        pulse_clr;
        chk("multi_cleared", MULTI, 0);

        for (int r = 0; r < 20; r++) begin
            hop_delay = $urandom_range(1, 6);
            any_multi = 0;
            for (int b = 0; b < $urandom_range(1, 4); b++) begin
                m = 4'($urandom_range(1, 15));
                if (!$onehot(m)) any_multi = 1;
                send(m, 1);
                repeat ($urandom_range(0, 3)) tick;
            end
            wait_idle("rand", 1000);
            chk("rand_paid", PAID, exp_paid);
            chk("rand_multi", MULTI, any_multi);
            chk("rand_ovf", OVF, 0);
            pulse_clr;
        end

        hop_delay = -1;
        send(4'b0100, 1);
        send(4'b0010, 1);
        send(4'b1000, 1);
        wait_motor("rstmid");
        #2 RST_N = 0;
        #1;
        chk("rstmid_motor", MOTOR, 0);
        chk("rstmid_busy", BUSY, 0);
        chk("rstmid_full", FULL, 0);
        chk("rstmid_paid", PAID, 0);
        chk("rstmid_jam", JAM, 0);
        exp_q.delete();
        exp_paid = 0;
        @(negedge CLK) RST_N = 1;
        repeat (6) tick;
        chk("rstmid_flushed", BUSY, 0);
        chk("rstmid_motor_idle", MOTOR, 0);
        hop_delay = 2;
        send(4'b1000, 1);
        wait_idle("rstmid", 100);
        chk("rstmid_paid_after", PAID, exp_paid);
        chk("rstmid_paid_abs", PAID, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
